// File: rtl/hazard_ctrl_multi_pkg.sv
// hazard_ctrl_multi_pkg
//   Shared types and constants for the ID-stage hazard controller.
//   state_e   : controller FSM states
//   cause_e   : stall_cause output codes
//   REG_ZERO  : architectural zero register, never a hazard source
//   *_CW      : counter widths sized for the supported parameter ranges
package hazard_ctrl_multi_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LD_WAIT  = 2'd1,
      ST_MDU_WAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_LOAD   = 2'd1,
      CAUSE_BRANCH = 2'd2,
      CAUSE_MDU    = 2'd3
   } cause_e;

   localparam int REG_ZERO = 0;
   localparam int LD_CW    = 2;  // holds LOAD_LAT-1 (max 3)
   localparam int MDU_CW   = 5;  // holds MDU_LAT-1 (max 31)
   localparam int FL_CW    = 2;  // holds FLUSH_DEPTH-1 (max 2)

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/hazard_ctrl_multi_if.sv
// hazard_ctrl_multi_if
//   Bundles the ID/EX/MEM hazard inputs and the pipeline control outputs.
//   master : pipeline side (drives *_i, observes *_o)
//   slave  : hazard controller (observes *_i, drives *_o)
interface hazard_ctrl_multi_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2
);
   logic [NUM_SRC*REG_AW-1:0] id_src_i;
   logic [NUM_SRC-1:0]        id_src_vld_i;
   logic                      id_branch_i;
   logic                      id_mdu_i;
   logic                      id_use_mdu_i;
   logic [REG_AW-1:0]         ex_rd_i;
   logic                      ex_wr_i;
   logic                      ex_memrd_i;
   logic [REG_AW-1:0]         mem_rd_i;
   logic                      mem_memrd_i;
   logic                      redirect_i;
   logic                      pc_write_o;
   logic                      ifid_write_o;
   logic                      idex_bubble_o;
   logic                      flush_o;
   logic                      mdu_start_o;
   logic [1:0]                stall_cause_o;
   logic [15:0]               stall_count_o;

   modport master (
      output id_src_i, id_src_vld_i, id_branch_i, id_mdu_i, id_use_mdu_i,
             ex_rd_i, ex_wr_i, ex_memrd_i, mem_rd_i, mem_memrd_i, redirect_i,
      input  pc_write_o, ifid_write_o, idex_bubble_o, flush_o, mdu_start_o,
             stall_cause_o, stall_count_o
   );

   modport slave (
      input  id_src_i, id_src_vld_i, id_branch_i, id_mdu_i, id_use_mdu_i,
             ex_rd_i, ex_wr_i, ex_memrd_i, mem_rd_i, mem_memrd_i, redirect_i,
      output pc_write_o, ifid_write_o, idex_bubble_o, flush_o, mdu_start_o,
             stall_cause_o, stall_count_o
   );
endinterface

// File: rtl/hazard_ctrl_multi_src_match.sv
// hazard_ctrl_multi_src_match
//   Compares one producer destination register against every valid ID
//   source operand.
//   rd_i    : producer destination register
//   src_i   : packed source regs, source k at [k*REG_AW +: REG_AW]
//   vld_i   : source k is actually read
//   match_o : some valid source equals rd_i and rd_i is not the zero reg
module hazard_ctrl_multi_src_match
   import hazard_ctrl_multi_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2
) (
   input  logic [REG_AW-1:0]         rd_i,
   input  logic [NUM_SRC*REG_AW-1:0] src_i,
   input  logic [NUM_SRC-1:0]        vld_i,
   output logic                      match_o
);
   logic [NUM_SRC-1:0] hit;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign hit[k] = vld_i[k] && (src_i[k*REG_AW +: REG_AW] == rd_i);
   end

   assign match_o = (rd_i != REG_AW'(REG_ZERO)) && (|hit);
endmodule

// File: rtl/hazard_ctrl_multi.sv
// hazard_ctrl_multi
//   ID-stage hazard controller: load-use, branch-in-ID and MDU interlocks,
//   multi-cycle flush after a redirect and a saturating stall counter.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   hif        : slave side of hazard_ctrl_multi_if (hazard inputs in,
//                pc_write/ifid_write/idex_bubble/flush/mdu_start/
//                stall_cause/stall_count out)
module hazard_ctrl_multi
   import hazard_ctrl_multi_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int MDU_LAT     = 4,
   parameter int FLUSH_DEPTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_ctrl_multi_if.slave hif
);
   state_e              state_q, state_d;
   logic [LD_CW-1:0]    ld_cnt_q, ld_cnt_d;
   logic [MDU_CW-1:0]   mdu_cnt_q, mdu_cnt_d;
   logic                mdu_busy_q, mdu_busy_d;
   logic [FL_CW-1:0]    fl_cnt_q, fl_cnt_d;
   logic [15:0]         stall_cnt_q;

   logic   match_ex, match_mem;
   logic   ld_hit, ld_stall, br_stall, mdu_stall, ld_wait;
   logic   stall, mdu_start;
   cause_e cause;

   hazard_ctrl_multi_src_match #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_match_ex (
      .rd_i(hif.ex_rd_i), .src_i(hif.id_src_i), .vld_i(hif.id_src_vld_i), .match_o(match_ex)
   );

   hazard_ctrl_multi_src_match #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) u_match_mem (
      .rd_i(hif.mem_rd_i), .src_i(hif.id_src_i), .vld_i(hif.id_src_vld_i), .match_o(match_mem)
   );

   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      mdu_cnt_d  = mdu_cnt_q;
      mdu_busy_d = mdu_busy_q;
      fl_cnt_d   = fl_cnt_q;
      stall      = 1'b0;
      mdu_start  = 1'b0;
      ld_wait    = 1'b0;
      cause      = CAUSE_NONE;

      ld_hit    = hif.ex_memrd_i && match_ex;
      ld_stall  = (state_q == ST_LD_WAIT) || ld_hit;
      br_stall  = hif.id_branch_i &&
                  ((hif.ex_wr_i && match_ex) || (hif.mem_memrd_i && match_mem));
      mdu_stall = mdu_busy_q && (hif.id_mdu_i || hif.id_use_mdu_i);

      // A redirect (re)arms the flush window; it runs down independently.
      if (hif.redirect_i)
         fl_cnt_d = FL_CW'(FLUSH_DEPTH - 1);
      else if (fl_cnt_q != '0)
         fl_cnt_d = fl_cnt_q - 1'b1;

      // Redirect outranks every stall source.
      if (!hif.redirect_i) begin
         stall = mdu_stall || br_stall || ld_stall;
         if (mdu_stall)     cause = CAUSE_MDU;
         else if (br_stall) cause = CAUSE_BRANCH;
         else if (ld_stall) cause = CAUSE_LOAD;
         // RUN implies the MDU is idle, so a clean id_mdu starts it.
         if (state_q == ST_RUN && hif.id_mdu_i && !stall)
            mdu_start = 1'b1;
      end

      // MDU counter keeps running through LD_WAIT and redirects; the cycle
      // where it reads 0 is still busy so MDU_LAT busy cycles follow start.
      if (mdu_busy_q) begin
         if (mdu_cnt_q == '0) mdu_busy_d = 1'b0;
         else                 mdu_cnt_d  = mdu_cnt_q - 1'b1;
      end
      if (mdu_start) begin
         mdu_busy_d = 1'b1;
         mdu_cnt_d  = MDU_CW'(MDU_LAT - 1);
      end

      // Multi-cycle load-use wait; a redirect abandons it.
      if (!hif.redirect_i) begin
         if (state_q == ST_LD_WAIT) begin
            if (ld_cnt_q != LD_CW'(1)) begin
               ld_wait  = 1'b1;
               ld_cnt_d = ld_cnt_q - 1'b1;
            end
         end else if (ld_hit && LOAD_LAT > 1) begin
            ld_wait  = 1'b1;
            ld_cnt_d = LD_CW'(LOAD_LAT - 1);
         end
      end

      if (ld_wait)         state_d = ST_LD_WAIT;
      else if (mdu_busy_d) state_d = ST_MDU_WAIT;
      else                 state_d = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         ld_cnt_q    <= '0;
         mdu_cnt_q   <= '0;
         mdu_busy_q  <= 1'b0;
         fl_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         mdu_cnt_q   <= mdu_cnt_d;
         mdu_busy_q  <= mdu_busy_d;
         fl_cnt_q    <= fl_cnt_d;
         stall_cnt_q <= stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;
      end
   end

   // Outputs are Mealy, so reset gates them directly to hold the pipeline
   // frozen while rst_n is low, independent of the clock.
   assign hif.pc_write_o    = rst_n && !stall;
   assign hif.ifid_write_o  = rst_n && !stall;
   assign hif.idex_bubble_o = !rst_n || stall;
   assign hif.flush_o       = rst_n && (hif.redirect_i || (fl_cnt_q != '0));
   assign hif.mdu_start_o   = rst_n && mdu_start;
   assign hif.stall_cause_o = rst_n ? cause : CAUSE_NONE;
   assign hif.stall_count_o = stall_cnt_q;
endmodule
